pulse_bram_arbiter: RTL

Sequences and shares the single-port pulse-histogram BRAM between `NUM_REQ` pulse-generator increment requesters and one host port. Each requester submits a byte address, and the block performs the one-cycle-latency read-modify-write (read, wait, write `dout+1`) on the BRAM. The host can read a bin, read-and-clear a bin, or sweep-clear the whole memory. The block sits between the pulse generators and the BRAM primitive, replacing their direct BRAM drive.

---
 rtl/pulse_bram_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pulse_bram_arbiter.sv
// rtl/pulse_bram_arbiter.sv - shares one single-port histogram BRAM between increment requesters, a host port and a sweep clear
module pulse_bram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      host_valid,
    input  logic                      host_clear,
    input  logic [ADDR_W-1:0]         host_addr,
    output logic                      host_ready,
    output logic [DATA_W-1:0]         host_rdata,
    output logic                      host_rvalid,
    input  logic                      sweep_start,
    output logic                      sweep_done,
    output logic                      bram_en,
    output logic                      bram_we,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [DATA_W-1:0]         bram_din,
    input  logic [DATA_W-1:0]         bram_dout,
    output logic [15:0]               drop_count,
    output logic                      busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-3:0] IDX_LIMIT = (ADDR_W-2)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((DEPTH - 1) * 4);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_SWEEP} state_t;
    typedef enum logic [1:0] {OP_INC, OP_HRD, OP_HCLR} op_t;

    state_t            state, state_nxt;
    op_t               op;
    logic [PTR_W-1:0]  rr_ptr, rr_idx, cand;
    logic              rr_any;
    logic              accept;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic              sweep_last;

    assign busy       = (state != S_IDLE);
    assign sweep_last = (bram_addr == LAST_ADDR);

    // Walk the requesters from the pointer downwards so the closest valid one wins.
    always_comb begin
        rr_any = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                rr_any = 1'b1;
                rr_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        host_ready = 1'b0;
        req_ready  = '0;
        accept     = 1'b0;
        sel_addr   = host_addr;
        sel_oor    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sweep_start) begin
                    state_nxt = S_SWEEP;
                end else if (host_valid) begin
                    host_ready = 1'b1;
                    accept     = 1'b1;
                end else if (rr_any) begin
                    req_ready[rr_idx] = 1'b1;
                    accept            = 1'b1;
                    sel_addr          = req_addr[int'(rr_idx)*ADDR_W +: ADDR_W];
                end
                sel_oor = (sel_addr[ADDR_W-1:2] >= IDX_LIMIT);
                if (accept && !sel_oor) state_nxt = S_RD;
            end
            S_RD:    state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_WR;
            S_WR:    state_nxt = S_IDLE;
            S_SWEEP: if (sweep_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op          <= OP_INC;
            rr_ptr      <= '0;
            bram_en     <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
            sweep_done  <= 1'b0;
            drop_count  <= '0;
        end else begin
            host_rvalid <= 1'b0;
            sweep_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_SWEEP) begin
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= '0;
                        bram_din  <= '0;
                    end else if (accept) begin
                        if (host_ready) begin
                            op <= host_clear ? OP_HCLR : OP_HRD;
                        end else begin
                            op     <= OP_INC;
                            rr_ptr <= (rr_idx == PTR_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
                        end
                        // Out-of-range requests are consumed without touching the BRAM.
                        if (sel_oor) begin
                            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        end else begin
                            bram_en   <= 1'b1;
                            bram_we   <= 1'b0;
                            bram_addr <= sel_addr & ~ADDR_W'(3);
                        end
                    end
                end
                S_RD: bram_en <= 1'b0;
                S_WAIT: begin
                    bram_en <= 1'b1;
                    bram_we <= 1'b1;
                    case (op)
                        OP_INC:  bram_din <= (bram_dout == '1) ? bram_dout : bram_dout + 1'b1;
                        OP_HRD:  bram_din <= bram_dout;
                        default: bram_din <= '0;
                    endcase
                    if (op != OP_INC) begin
                        host_rdata  <= bram_dout;
                        host_rvalid <= 1'b1;
                    end
                end
                S_WR: begin
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                end
                S_SWEEP: begin
                    if (sweep_last) begin
                        bram_en    <= 1'b0;
                        bram_we    <= 1'b0;
                        sweep_done <= 1'b1;
                    end else begin
                        bram_addr <= bram_addr + ADDR_W'(4);
                    end
                end
                default: begin
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                end
            endcase
        end
    end
endmodule
